mcu_uart_rx: RTL and testbench
==============================

Name: mcu_uart_rx

Overview:
- UART receiver for the PulseRain RV2T MCU, the receive counterpart of the MCU's TXD path.
- Takes the board RXD line (shared with the debug coprocessor input) and recovers 8N1 frames at BAUD_PERIOD clocks per bit.
- Received bytes go into a small first-word-fall-through FIFO that the MCU peripheral bus reads.
- Flags framing errors, overflow and an optional parity error.

Parameters:
- BAUD_PERIOD, default `UART_TX_BAUD_PERIOD: clock cycles per bit; must be at least 8.
- FIFO_DEPTH, default 4: number of byte entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock, HSOSC-derived.
- reset  input  1  asynchronous, active-high reset.
- RXD  input  1  serial input, idle high, asynchronous to clk.
- read_ack  input  1  pops the FIFO head; ignored while data_valid=0.
- clear_errors  input  1  clears the sticky error flags.
- data_out  output  8  FIFO head byte; valid only while data_valid=1.
- data_valid  output  1  FIFO not empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- framing_error  output  1  sticky: a stop bit was sampled low.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- parity_error  output  1  sticky; exists only with the optional feature, tied to 0 otherwise.
- rx_busy  output  1  high while the state machine is in any state except IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - All outputs 0, including data_out = 8'h00.
  - FIFO empty, state IDLE.
  - Both synchronizer flops set to 1.
- Synchronizer: RXD passes through 2 flops to give rxd_s. All decisions use rxd_s.
- Bit counter: counts BAUD_PERIOD-1 down to 0. Width is $clog2(BAUD_PERIOD).
- State machine:
  - IDLE: when rxd_s=0, load the counter with BAUD_PERIOD/2-1 and go to START.
  - START: at counter 0, sample rxd_s.
    - 1: false start, return to IDLE; nothing else changes.
    - 0: reload the counter with BAUD_PERIOD-1, clear the bit index, go to DATA.
  - DATA: at each counter 0, shift rxd_s in LSB first and reload the counter. After bit index 7, go to STOP (or PARITY with the option).
  - STOP: at counter 0, sample rxd_s.
    - 1: push the byte, go to IDLE.
    - 0: set framing_error, discard the byte, go to BREAK.
  - BREAK: stay until rxd_s=1, then go to IDLE. A line held low therefore generates exactly one framing error.
- Sampling point: each bit is sampled mid-bit, ±1 clock.
- Latency:
  - The push happens in the cycle of the stop-bit sample.
  - data_valid rises on the following edge.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Full when the pointer MSBs differ and the remaining bits are equal. Empty when the pointers are equal.
  - data_out is combinational from the head entry.
- Boundary cases:
  - Push while full with no pop: the byte is dropped and overflow is set. FIFO contents are unchanged.
  - Push while full with a pop in the same cycle: both operations happen, no overflow.
  - Push and pop together when not empty: the occupancy is unchanged.
  - Pop while empty: ignored.
- Error flags:
  - clear_errors clears every sticky flag.
  - If a flag is set and cleared in the same cycle, set wins.
- Reset mid-frame: the frame is abandoned, the FIFO is emptied and the receiver returns to IDLE. The next falling edge starts a new frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit (one full BAUD_PERIOD).
  - A mismatch sets parity_error; the byte is still pushed if the stop bit is good.
- Undefined:
  - No PARITY state; frames are 8N1.
  - parity_error is a constant 0.

Test Plan:
- BAUD_PERIOD=16. Send 8'hA5 as 8N1 → data_valid rises 1 cycle after the stop sample, data_out=8'hA5. One read_ack → data_valid=0.
- Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 back-to-back with no reads, FIFO_DEPTH=4 → fifo_full=1 after the 4th byte, overflow=1. Reads return 01..04 and 05 is lost. clear_errors → overflow=0.
- Send 8'h3C with the stop bit low and the line held low for 40 bit times → framing_error=1 exactly once, no push. After RXD returns high, 8'h7E is received correctly.
- 5-clock low glitch on idle RXD → START rejects it; no push, no error, rx_busy returns to 0.
- FIFO full, assert read_ack in the exact cycle of the stop-bit push of 8'h99 → no overflow, fifo_full stays 1, 8'h99 is at the tail.
- With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 (wrong for even parity) → parity_error=1 and 8'h07 is pushed. Assert reset mid-frame → data_valid=0, all flags 0.

Source files
------------

// File: rtl/mcu_uart_rx.sv
// rtl/mcu_uart_rx.sv - 8N1 UART receiver with FWFT byte FIFO and sticky error flags.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
`ifndef UART_TX_BAUD_PERIOD
`define UART_TX_BAUD_PERIOD 16
`endif

module mcu_uart_rx #(
  parameter int BAUD_PERIOD = `UART_TX_BAUD_PERIOD,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  input  logic       read_ack,
  input  logic       clear_errors,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       framing_error,
  output logic       overflow,
  output logic       parity_error,
  output logic       rx_busy
);

  localparam int CW = $clog2(BAUD_PERIOD);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_PERIOD / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state, state_next;
  logic            rxd_meta, rxd_s;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift, shift_next;
  logic            push;
  logic            set_framing;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic set_parity;
`endif

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    push         = 1'b0;
    set_framing  = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_parity   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          cnt_next   = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else if (rxd_s) begin
          state_next = IDLE;
        end else begin
          cnt_next     = FULL_LOAD;
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else begin
          shift_next   = {rxd_s, shift[7:1]};
          cnt_next     = FULL_LOAD;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else begin
          set_parity = (rxd_s != ^shift);
          cnt_next   = FULL_LOAD;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else if (rxd_s) begin
          push       = 1'b1;
          state_next = IDLE;
        end else begin
          set_framing = 1'b1;
          state_next  = BREAK;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it reports one framing error, not many.
        if (rxd_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = read_ack && !empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign data_out   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign data_valid = !empty;
  assign fifo_full  = full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (set_framing)       framing_error <= 1'b1;
      else if (clear_errors) framing_error <= 1'b0;
      if (drop)              overflow <= 1'b1;
      else if (clear_errors) overflow <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             parity_error <= 1'b0;
    else if (set_parity)   parity_error <= 1'b1;
    else if (clear_errors) parity_error <= 1'b0;
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_uart_rx.sv
// tb/tb_mcu_uart_rx.sv - directed and random frames against a queue-based receiver model.
// Parity frames are exercised only when UART_RX_PARITY_EN is defined.
module tb_mcu_uart_rx;

  localparam int BP    = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Two synchronizer edges, one IDLE edge, half a bit to the start sample, then full bits to stop.
  localparam int STOP_EDGE = 3 + BP / 2 + (NBITS - 1) * BP;

  logic       clk = 1'b0;
  logic       reset, RXD, read_ack, clear_errors;
  logic [7:0] data_out;
  logic       data_valid, fifo_full, framing_error, overflow, parity_error, rx_busy;

  int   checks = 0;
  int   errors = 0;
  int   rise_edge;
  logic [7:0] exp_q[$];
  bit   exp_fe, exp_ov, exp_pe;

  mcu_uart_rx #(.BAUD_PERIOD(BP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .RXD(RXD), .read_ack(read_ack), .clear_errors(clear_errors),
    .data_out(data_out), .data_valid(data_valid), .fifo_full(fifo_full),
    .framing_error(framing_error), .overflow(overflow), .parity_error(parity_error),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame, asserting read_ack during the cycle that ends on edge pop_at+1.
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bit,
                            input int pop_at);
    logic [11:0] bits;
    bit was_empty;
`ifdef UART_RX_PARITY_EN
    bits = {1'b1, stop_bit, par_bit, d, 1'b0};
`else
    bits = {2'b11, stop_bit, d, 1'b0};
    if (par_bit) bits[11] = 1'b1;
`endif
    was_empty = !data_valid;
    rise_edge = -1;
    for (int n = 0; n < NBITS * BP; n++) begin
      RXD = bits[n / BP];
      read_ack = (n == pop_at);
      @(posedge clk);
      #1;
      read_ack = 1'b0;
      if (was_empty && rise_edge < 0 && data_valid) rise_edge = n + 1;
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_bit);
    if (!stop_ok) exp_fe = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ov = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (par_bit != ^d) exp_pe = 1'b1;
`else
    if (par_bit) exp_pe = exp_pe;
`endif
  endtask

  task automatic rx_byte(input logic [7:0] d);
    send_frame(d, 1'b1, ^d, -1);
    model_frame(d, 1'b1, ^d);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_valid"}, data_valid, exp_q.size() != 0);
    chk({tag, "_full"}, fifo_full, exp_q.size() == DEPTH);
    chk({tag, "_ferr"}, framing_error, exp_fe);
    chk({tag, "_ovf"}, overflow, exp_ov);
    chk({tag, "_perr"}, parity_error, exp_pe);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, data_valid, 1'b1);
    chk({tag, "_data"}, data_out, e);
    read_ack = 1'b1;
    tick(1);
    read_ack = 1'b0;
  endtask

  task automatic clear_flags();
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    exp_pe = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    int k;
    reset = 1'b1; RXD = 1'b1; read_ack = 1'b0; clear_errors = 1'b0;
    exp_fe = 1'b0; exp_ov = 1'b0; exp_pe = 1'b0;
    tick(4);
    chk("rst_data", data_out, 8'h00);
    chk("rst_busy", rx_busy, 1'b0);
    chk_state("rst");
    reset = 1'b0;
    tick(4);

    // Single byte: data_valid timing, then a pop empties the FIFO.
    rx_byte(8'hA5);
    chk("a5_rise_edge", rise_edge, STOP_EDGE);
    pop_check("a5");
    chk("a5_empty", data_valid, 1'b0);

    // Overflow on the fifth back-to-back byte.
    for (int i = 1; i <= 5; i++) begin
      rx_byte(8'(i));
      if (i == 4) chk("fill4_full", fifo_full, 1'b1);
    end
    chk_state("ovf");
    for (int i = 0; i < 4; i++) pop_check("ovf_drain");
    chk("ovf_empty", data_valid, 1'b0);
    clear_flags();
    chk_state("ovf_clr");

    // Bad stop bit, line held low: a single framing error, no push.
    send_frame(8'h3C, 1'b0, ^8'h3C, -1);
    model_frame(8'h3C, 1'b0, ^8'h3C);
    chk_state("brk");
    clear_flags();
    tick(40 * BP - 1);
    chk("brk_no_rerr", framing_error, 1'b0);
    chk("brk_busy", rx_busy, 1'b1);
    RXD = 1'b1;
    tick(BP);
    chk("brk_idle", rx_busy, 1'b0);
    chk_state("brk_rel");
    rx_byte(8'h7E);
    pop_check("after_brk");

    // Short low glitch is rejected at the start-bit sample.
    RXD = 1'b0;
    tick(5);
    RXD = 1'b1;
    chk("glitch_busy", rx_busy, 1'b1);
    tick(20);
    chk("glitch_idle", rx_busy, 1'b0);
    chk_state("glitch");

    // Pop coincident with a push into a full FIFO.
    for (int i = 0; i < DEPTH; i++) rx_byte(8'($urandom_range(0, 255)));
    send_frame(8'h99, 1'b1, ^8'h99, STOP_EDGE - 1);
    void'(exp_q.pop_front());
    model_frame(8'h99, 1'b1, ^8'h99);
    chk_state("simul");
    for (int i = 0; i < DEPTH; i++) pop_check("simul_drain");

    // Random bursts with random drains.
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < k; i++) begin
        rb = 8'($urandom_range(0, 255));
        rx_byte(rb);
      end
      chk_state("rnd");
      k = $urandom_range(0, exp_q.size());
      for (int i = 0; i < k; i++) pop_check("rnd_pop");
      if (exp_ov) clear_flags();
    end
    while (exp_q.size() != 0) pop_check("rnd_flush");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1);
    model_frame(8'h07, 1'b1, 1'b0);
    chk("par_err", parity_error, 1'b1);
    chk_state("par");
    pop_check("par_byte");
    clear_flags();
`endif

    // Reset mid-frame with data queued and a sticky flag set.
    for (int i = 0; i < DEPTH + 1; i++) rx_byte(8'($urandom_range(0, 255)));
    chk_state("pre_rst");
    for (int n = 0; n < 70; n++) begin
      RXD = (n < BP) ? 1'b0 : n[4];
      tick(1);
    end
    #3 reset = 1'b1;
    #1;
    exp_q.delete();
    exp_fe = 1'b0; exp_ov = 1'b0; exp_pe = 1'b0;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_busy", rx_busy, 1'b0);
    chk_state("mid_rst");
    RXD = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    rb = 8'($urandom_range(0, 255));
    rx_byte(rb);
    chk("post_rst_rise", rise_edge, STOP_EDGE);
    pop_check("post_rst");
    chk_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
